// File: rtl/video_mem_port.sv
// video_mem_port: shares one 1-cycle-latency byte memory between the video
// controller's fetch port and a CPU requester. Every pixel period has four
// clocks; the video fetch owns phase 1 and the CPU owns phase 3, so video
// reads are never delayed by CPU traffic.
module video_mem_port #(
   parameter int AW = 17
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          ce_pix,
   input  logic [AW-1:0] vid_addr,
   output logic [7:0]    vid_din,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_dout,
   output logic [7:0]    cpu_din,
   output logic          cpu_ack,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [7:0]    mem_wdata,
   input  logic [7:0]    mem_q
);

   // Phase of the pixel period; PH3 is where ce_pix normally lands.
   typedef enum logic [1:0] {
      PH0 = 2'd0,
      PH1 = 2'd1,
      PH2 = 2'd2,
      PH3 = 2'd3
   } phase_t;

   phase_t          r_phase;
   phase_t          w_phase_nxt;

   logic [AW-1:0]   r_mem_addr;
   logic            r_mem_rd;
   logic            r_mem_wr;
   logic [7:0]      r_mem_wdata;
   logic [AW-1:0]   w_mem_addr_nxt;
   logic            w_mem_rd_nxt;
   logic            w_mem_wr_nxt;
   logic [7:0]      w_mem_wdata_nxt;

   logic [7:0]      r_vid_din;
   logic [7:0]      r_cpu_din;
   logic            r_cpu_ack;

   // CPU completion tracker: bit 0 is set on issue, bit 1 one edge later,
   // and the ack fires on the edge after that. It runs independently of
   // the phase so a shortened pixel period can never lose an ack.
   logic [1:0]      r_vld_pipe;
   logic [1:0]      r_rd_pipe;

   logic            w_busy;
   logic            w_cpu_issue;
   logic            w_vid_cap;

   assign mem_addr  = r_mem_addr;
   assign mem_rd    = r_mem_rd;
   assign mem_wr    = r_mem_wr;
   assign mem_wdata = r_mem_wdata;
   assign vid_din   = r_vid_din;
   assign cpu_din   = r_cpu_din;
   assign cpu_ack   = r_cpu_ack;

   assign w_busy    = |r_vld_pipe;

   // Phase counter next state: ce_pix resynchronises to PH0 at any time.
   always_comb begin
      w_phase_nxt = phase_t'(r_phase + 2'd1);
      if (ce_pix) begin
         w_phase_nxt = PH0;
      end
   end

   // Slot decode: what the memory port does on the edge ending each phase.
   // Strobes default to 0 so anything issued last edge is cleared, except
   // that a PH0 video issue simply overrides whatever the CPU left behind.
   always_comb begin
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_rd_nxt    = 1'b0;
      w_mem_wr_nxt    = 1'b0;
      w_mem_wdata_nxt = r_mem_wdata;
      w_cpu_issue     = 1'b0;
      w_vid_cap       = 1'b0;
      case (r_phase)
         PH0: begin
            w_mem_addr_nxt = vid_addr;
            w_mem_rd_nxt   = 1'b1;
         end
         PH2: begin
            // Video data from the PH1 read is on mem_q now.
            w_vid_cap = 1'b1;
            if (cpu_req && !w_busy) begin
               w_cpu_issue     = 1'b1;
               w_mem_addr_nxt  = cpu_addr;
               w_mem_rd_nxt    = ~cpu_we;
               w_mem_wr_nxt    = cpu_we;
               w_mem_wdata_nxt = cpu_dout;
            end
         end
         default: begin
            // PH1 and PH3: strobes drop, address and data hold.
         end
      endcase
   end

   // Phase register and registered memory port.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_phase     <= PH0;
         r_mem_addr  <= '0;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_wdata <= '0;
      end else begin
         r_phase     <= w_phase_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_rd    <= w_mem_rd_nxt;
         r_mem_wr    <= w_mem_wr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
      end
   end

   // Video capture; holds through PH3 for the controller's ce_pix sample,
   // and holds across any period that skipped PH2.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_vid_din <= '0;
      end else if (w_vid_cap) begin
         r_vid_din <= mem_q;
      end
   end

   // CPU completion: two edges after issue, pulse ack and capture read data.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_vld_pipe <= '0;
         r_rd_pipe  <= '0;
         r_cpu_ack  <= 1'b0;
         r_cpu_din  <= '0;
      end else begin
         r_vld_pipe <= {r_vld_pipe[0], w_cpu_issue};
         r_rd_pipe  <= {r_rd_pipe[0], w_cpu_issue & ~cpu_we};
         r_cpu_ack  <= r_vld_pipe[1];
         if (r_vld_pipe[1] && r_rd_pipe[1]) begin
            r_cpu_din <= mem_q;
         end
      end
   end

endmodule

// File: tb/tb_video_mem_port.sv
// tb_video_mem_port: drives regular and shortened pixel periods with a mix of
// directed and random CPU traffic, and checks against a period-ordered
// reference memory: in each period the video fetch sees memory before that
// period's CPU access, and the CPU access completes one period later.
module tb_video_mem_port;

   localparam int AW = 17;

   logic          clk_sys = 1'b0;
   logic          reset;
   logic          ce_pix;
   logic [AW-1:0] vid_addr;
   logic [7:0]    vid_din;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_dout;
   logic [7:0]    cpu_din;
   logic          cpu_ack;
   logic [AW-1:0] mem_addr;
   logic          mem_rd;
   logic          mem_wr;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_q;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] ram     [0:(1<<AW)-1];
   logic [7:0] ref_mem [0:(1<<AW)-1];

   // Outstanding CPU completion expected at phase 1 of the next period.
   bit         pend_ack;
   bit         pend_rd;
   logic [7:0] pend_din;

   video_mem_port #(.AW(AW)) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .ce_pix    (ce_pix),
      .vid_addr  (vid_addr),
      .vid_din   (vid_din),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_dout  (cpu_dout),
      .cpu_din   (cpu_din),
      .cpu_ack   (cpu_ack),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .mem_q     (mem_q)
   );

   always #5 clk_sys = ~clk_sys;

   // Initial memory image shared by the RAM model and the reference.
   function automatic logic [7:0] init_val(int i);
      if (i == 'h1A2B0) return 8'h5A;
      if (i >= 'h10 && i <= 'h17) return 8'(i);
      return 8'((i * 37) ^ (i >> 7));
   endfunction

   // Main RAM: 1-cycle read latency, write on the strobed edge.
   initial begin
      for (int i = 0; i < (1 << AW); i++) ram[i] = init_val(i);
      mem_q = 8'h00;
   end

   always @(posedge clk_sys) begin
      if (mem_wr) ram[mem_addr] <= mem_wdata;
      if (mem_rd) mem_q <= ram[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".mem_addr"},  32'(mem_addr),  32'h0);
      chk({tag, ".mem_rd"},    32'(mem_rd),    32'h0);
      chk({tag, ".mem_wr"},    32'(mem_wr),    32'h0);
      chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'h0);
      chk({tag, ".vid_din"},   32'(vid_din),   32'h0);
      chk({tag, ".cpu_din"},   32'(cpu_din),   32'h0);
      chk({tag, ".cpu_ack"},   32'(cpu_ack),   32'h0);
   endtask

   function automatic logic [16:0] rand_addr();
      logic [16:0] a;
      a = 17'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) a = a | 17'h1FFE0;
      return a;
   endfunction

   // One regular 4-clock pixel period. Entered just after the edge that
   // starts phase 0; left just after the edge that starts the next phase 0.
   // raise_ph picks the phase in which a fresh request is raised (0..2);
   // abort asserts reset in phase 3 instead of finishing the period.
   task automatic run_period(input logic [16:0] va, input bit do_cpu, input bit we,
                             input logic [16:0] ca, input logic [7:0] cd,
                             input int raise_ph, input bit abort);
      int  rp;
      bit  exp_ack;
      rp      = pend_ack ? 2 : raise_ph;
      exp_ack = pend_ack;
      for (int p = 0; p < 4; p++) begin
         ce_pix = (p == 3);
         if (p == 0) vid_addr = va;
         if (p == rp && do_cpu) begin
            cpu_req  = 1'b1;
            cpu_we   = we;
            cpu_addr = ca;
            cpu_dout = cd;
         end else if (p == 2 && !do_cpu) begin
            cpu_req = 1'b0;
         end
         @(negedge clk_sys);
         case (p)
            0: begin
               chk("ph0.mem_rd",  32'(mem_rd),  32'h0);
               chk("ph0.mem_wr",  32'(mem_wr),  32'h0);
               chk("ph0.cpu_ack", 32'(cpu_ack), 32'h0);
            end
            1: begin
               chk("vid.mem_rd",   32'(mem_rd),   32'h1);
               chk("vid.mem_wr",   32'(mem_wr),   32'h0);
               chk("vid.mem_addr", 32'(mem_addr), 32'(va));
               chk("ph1.cpu_ack",  32'(cpu_ack),  32'(exp_ack));
               if (exp_ack && pend_rd) chk("cpu_din", 32'(cpu_din), 32'(pend_din));
               pend_ack = 1'b0;
            end
            2: begin
               chk("ph2.mem_rd",  32'(mem_rd),  32'h0);
               chk("ph2.mem_wr",  32'(mem_wr),  32'h0);
               chk("ph2.cpu_ack", 32'(cpu_ack), 32'h0);
            end
            default: begin
               chk("vid_din",      32'(vid_din), 32'(ref_mem[va]));
               chk("ph3.mem_rd",   32'(mem_rd),  32'(do_cpu && !we));
               chk("ph3.mem_wr",   32'(mem_wr),  32'(do_cpu && we));
               chk("ph3.cpu_ack",  32'(cpu_ack), 32'h0);
               if (do_cpu) chk("cpu.mem_addr", 32'(mem_addr), 32'(ca));
               if (do_cpu && we) chk("cpu.mem_wdata", 32'(mem_wdata), 32'(cd));
            end
         endcase
         if (p == 3 && abort) begin
            #2 reset = 1'b1;
            #1 chk_all_zero("rst_mid");
            ce_pix  = 1'b0;
            cpu_req = 1'b0;
            pend_ack = 1'b0;
            @(posedge clk_sys);
            @(posedge clk_sys);
            #1 reset = 1'b0;
            return;
         end
         if (p == 3) begin
            if (do_cpu) begin
               if (we) ref_mem[ca] = cd;
               else    pend_din    = ref_mem[ca];
            end
            pend_ack = do_cpu;
            pend_rd  = !we;
         end
         next_cyc();
      end
   endtask

   // Shortened periods: 3-clock period P (ce_pix in phase 2) issues a CPU
   // read, then ce_pix in phase 1 of Q while that read is still in flight.
   task automatic run_early();
      logic [16:0] va_p, va_q, va_r, ca;
      va_p = 17'h00200;
      va_q = 17'h00201;
      va_r = 17'h00202;
      ca   = 17'h00300;
      // P ph0
      ce_pix = 1'b0; vid_addr = va_p;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ca; cpu_dout = 8'h00;
      @(negedge clk_sys);
      chk("ePph0.cpu_ack", 32'(cpu_ack), 32'h0);
      next_cyc();
      // P ph1
      @(negedge clk_sys);
      chk("ePph1.mem_rd",   32'(mem_rd),   32'h1);
      chk("ePph1.mem_addr", 32'(mem_addr), 32'(va_p));
      next_cyc();
      // P ph2, early ce_pix; CPU read issues at this edge
      ce_pix = 1'b1;
      @(negedge clk_sys);
      chk("ePph2.mem_rd", 32'(mem_rd), 32'h0);
      next_cyc();
      // Q ph0: CPU read on the port, vid_din from P
      ce_pix = 1'b0; vid_addr = va_q;
      @(negedge clk_sys);
      chk("eQph0.vid_din",  32'(vid_din),  32'(ref_mem[va_p]));
      chk("eQph0.mem_rd",   32'(mem_rd),   32'h1);
      chk("eQph0.mem_addr", 32'(mem_addr), 32'(ca));
      chk("eQph0.cpu_ack",  32'(cpu_ack),  32'h0);
      next_cyc();
      // Q ph1, early ce_pix while the read is in flight
      ce_pix = 1'b1;
      @(negedge clk_sys);
      chk("eQph1.mem_addr", 32'(mem_addr), 32'(va_q));
      chk("eQph1.cpu_ack",  32'(cpu_ack),  32'h0);
      next_cyc();
      // R ph0: ack two edges after issue, vid_din untouched by Q
      ce_pix = 1'b0; vid_addr = va_r; cpu_req = 1'b0;
      @(negedge clk_sys);
      chk("eRph0.cpu_ack", 32'(cpu_ack), 32'h1);
      chk("eRph0.vid_din", 32'(vid_din), 32'(ref_mem[va_p]));
      chk("eRph0.mem_rd",  32'(mem_rd),  32'h0);
      next_cyc();
      // R ph1: phase was resynchronised, so the video fetch happens now
      @(negedge clk_sys);
      chk("eRph1.cpu_ack",  32'(cpu_ack),  32'h0);
      chk("eRph1.mem_rd",   32'(mem_rd),   32'h1);
      chk("eRph1.mem_addr", 32'(mem_addr), 32'(va_r));
      next_cyc();
      // R ph2
      @(negedge clk_sys);
      chk("eRph2.mem_rd", 32'(mem_rd), 32'h0);
      next_cyc();
      // R ph3
      ce_pix = 1'b1;
      @(negedge clk_sys);
      chk("eRph3.vid_din", 32'(vid_din), 32'(ref_mem[va_r]));
      next_cyc();
      pend_ack = 1'b0;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
      pend_ack = 1'b0; pend_rd = 1'b0; pend_din = 8'h00;
      reset = 1'b1; ce_pix = 1'b0; vid_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_dout = 8'h00;
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      chk_all_zero("reset");
      @(posedge clk_sys);
      #1 reset = 1'b0;

      // Video read of the preloaded 0x5A.
      run_period(17'h1A2B0, 1'b0, 1'b0, '0, 8'h00, 2, 1'b0);
      // CPU write then video readback of the same byte.
      run_period(17'h00400, 1'b1, 1'b1, 17'h00123, 8'hC3, 2, 1'b0);
      run_period(17'h00123, 1'b0, 1'b0, '0, 8'h00, 2, 1'b0);
      // Back-to-back CPU reads with video running.
      for (int i = 0; i < 8; i++)
         run_period(17'h00800 + 17'(i), 1'b1, 1'b0, 17'h00010 + 17'(i), 8'h00, 0, 1'b0);
      run_period(17'h00016, 1'b0, 1'b0, '0, 8'h00, 2, 1'b0);
      // Shortened periods with a read in flight.
      run_early();
      run_period(17'h00300, 1'b0, 1'b0, '0, 8'h00, 2, 1'b0);
      // Reset in phase 3 of a write; the byte must not change.
      run_period(17'h00500, 1'b1, 1'b1, 17'h00501, 8'hE7, 1, 1'b1);
      run_period(17'h00501, 1'b0, 1'b0, '0, 8'h00, 2, 1'b0);
      run_period(17'h00502, 1'b1, 1'b0, 17'h00501, 8'h00, 2, 1'b0);
      run_period(17'h00503, 1'b0, 1'b0, '0, 8'h00, 2, 1'b0);
      // Random traffic over a small address pool to force read-after-write.
      for (int k = 0; k < 250; k++) begin
         logic [16:0] va, ca;
         logic [7:0]  cd;
         bit          dc, we;
         int          rp;
         va = rand_addr();
         ca = rand_addr();
         cd = 8'($urandom);
         dc = ($urandom_range(0, 3) != 0);
         we = ($urandom_range(0, 1) == 1);
         rp = $urandom_range(0, 2);
         run_period(va, dc, we, ca, cd, rp, 1'b0);
      end
      run_period(17'h00000, 1'b0, 1'b0, '0, 8'h00, 2, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/video_mem_port.md
# video_mem_port

Shared-memory responder for the video controller's read port. Serves the video controller's `vid_addr`/`din` fetches (pixel bytes and roller-RAM words) from a single 17-bit, 1-cycle-latency byte memory. Gives the remaining slot of every pixel period to a CPU-side read/write requester, so video reads are never delayed. Sits between the video controller, the Z80 memory mapper and the main RAM instance.

## Interface
Parameters:
- `AW`, 17: memory address width.

Ports:
- `clk_sys`  in  1  system clock, 64 MHz.
- `reset`  in  1  reset, asynchronous, active-high.
- `ce_pix`  in  1  pixel strobe, one clock in four; same strobe the video controller uses.
- `vid_addr`  in  AW  video fetch address; changes only on the clock edge where `ce_pix` is high.
- `vid_din`  out  8  fetched byte returned to the video controller's `din`.
- `cpu_req`  in  1  CPU request; a level held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read; held with `cpu_req`.
- `cpu_addr`  in  AW  CPU address.
- `cpu_dout`  in  8  CPU write data.
- `cpu_din`  out  8  CPU read data, valid while `cpu_ack` is high and held afterwards.
- `cpu_ack`  out  1  one-clock completion pulse.
- `mem_addr`  out  AW  memory address, registered.
- `mem_rd`  out  1  memory read strobe, registered.
- `mem_wr`  out  1  memory write strobe, registered.
- `mem_wdata`  out  8  memory write data, registered.
- `mem_q`  in  8  memory read data; valid in the cycle after the cycle in which `mem_rd` is high.

## Operation
- **Phase counter `phase[1:0]`.** Next value is 0 if `ce_pix` is high, otherwise `phase + 1`. In steady state `ce_pix` is high during phase 3.
- **Video slot, issue (edge ending phase 0).** `mem_addr <= vid_addr`, `mem_rd <= 1`, `mem_wr <= 0`. The memory therefore sees the video request during phase 1.
- **Strobe clear (edge ending phase 1).** `mem_rd <= 0`, `mem_wr <= 0`.
- **Video slot, capture (edge ending phase 2).** `vid_din <= mem_q`. `vid_din` is stable through phase 3, so the video controller samples it on its `ce_pix` edge.
- **CPU slot, issue (edge ending phase 2).** Occurs only if `cpu_req` is high and `inflight` is 0:
  - `mem_addr <= cpu_addr`, `mem_rd <= ~cpu_we`, `mem_wr <= cpu_we`, `mem_wdata <= cpu_dout`, `inflight <= 1`.
  - If no CPU request is issued, `mem_rd` and `mem_wr` stay 0 through phase 3.
- **CPU completion.** `inflight` is a 2-stage tracker that is not tied to phase.
  - Two edges after issue: `cpu_din <= mem_q` (reads only; writes leave `cpu_din` unchanged), `cpu_ack <= 1`, `inflight <= 0`.
  - `cpu_ack` is high for exactly one clock.
- **Strobe ownership.** Strobes issued at the phase-2 edge are cleared at the next edge unless that edge is a phase-0 video issue, which overrides them.
- **CPU protocol.**
  - The requester drops `cpu_req`, or presents a new request, at the edge where it sees `cpu_ack`.
  - A `cpu_req` still high at the next phase-2 edge is treated as a new transaction.
- **Throughput and priority.**
  - At most one CPU transaction per pixel period.
  - Video always has priority. The CPU never stalls video.

## Timing
- **Reset values.** All outputs and all state are 0: `phase`, `mem_addr`, `mem_rd`, `mem_wr`, `mem_wdata`, `vid_din`, `cpu_din`, `cpu_ack`, `inflight`. The phase counter free-runs from 0 after reset.
- **Video latency.** `vid_addr` is presented in phase 0 and the corresponding data is on `vid_din` during phase 3 of the same period, i.e. one pixel period from address to sample.
- **CPU latency.** 1 to 4 clocks from `cpu_req` to the issue edge, plus 2 clocks to `cpu_ack`. In steady state `cpu_ack` is high during phase 1.
- **Early `ce_pix` (period shorter than 4 clocks).**
  - `phase` resynchronises to 0.
  - Actions stay keyed to the phase value in force at each edge. A skipped phase 2 means `vid_din` holds its previous value.
  - An in-flight CPU transaction always completes on its 2-edge schedule. Acks are never dropped.
  - If a video issue collides with the CPU's request cycle, the video issue wins `mem_addr`. The CPU still captures `mem_q` on schedule, and the resulting data is undefined.
  - The bench checks that `cpu_ack` still arrives; data correctness is only required under regular `ce_pix`.
- **Reset mid-transaction.** Asynchronous clear. No `cpu_ack` is produced for the aborted request. `mem_wr` drops immediately.
- **Simultaneous events.** When `cpu_req` rises in the same cycle as phase 2, the request is accepted at that edge.

## Test plan
- **Video read.** Memory model holds 0x5A at 0x1A2B0; set `vid_addr`=0x1A2B0 at a `ce_pix` edge. Expect `mem_rd`=1 with `mem_addr`=0x1A2B0 for phase 1 only, and `vid_din`=0x5A during phase 3.
- **CPU write, then video readback.** `cpu_req`=1, `cpu_we`=1, `cpu_addr`=0x00123, `cpu_dout`=0xC3. Expect `mem_wr`=1 with `mem_wdata`=0xC3 in phase 3 only, and `cpu_ack` for one clock in the next phase 1. A video fetch of 0x00123 in the following period then returns 0xC3.
- **Back-to-back CPU reads with video running.** CPU holds `cpu_req` and reads 0x00010..0x00017 (data 0x10..0x17). Expect one ack per pixel period with `cpu_din` matching, and every concurrent `vid_din` correct.
- **Reset mid-write.** Assert `reset` during phase 3 of a CPU write. Expect all outputs 0 immediately, no `cpu_ack`, and normal operation after release.
- **Early `ce_pix`.** Pulse `ce_pix` in phase 1 while a CPU read is in flight. Expect `phase`=0 on the next cycle, `vid_din` unchanged, and `cpu_ack` still 2 edges after issue.
